sram_controller: RTL
====================

Name: sram_controller

Overview:
- Sequences MEM-stage data accesses of the ARM pipeline onto an external 16-bit-wide SRAM.
- Inputs are mem_read/mem_write as decoded by the control unit, plus the ALU-computed address and the store data.
- Each 32-bit word access is split into two 16-bit half-word phases, each held for WAIT_CYCLES clocks.
- ready stays low for the whole access so the hazard/freeze logic can stall the pipeline.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM location 0.
- WAIT_CYCLES, 3: clocks each half-word phase is held; legal range 1..15.
- SRAM_AW, 18: SRAM address width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset.
- mem_read  input  1  load request from MEM stage.
- mem_write  input  1  store request from MEM stage.
- address  input  32  byte address from the ALU result.
- write_data  input  32  store data (Rd value).
- read_data  output  32  load result; valid while ready=1 after a read.
- ready  output  1  0 = access in progress, pipeline must freeze.
- sram_addr  output  SRAM_AW  SRAM half-word address.
- sram_dq_out  output  16  data driven to SRAM.
- sram_dq_oe  output  1  1 = drive sram_dq_out onto the pad.
- sram_dq_in  input  16  data returned from the SRAM pad.
- sram_we_n  output  1  active-low write enable.

Behaviour:
- Reset: rst=1 at a clock edge forces state IDLE, counter 0, read_data 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1.
- Reset aborts any access in progress; no further SRAM write strobe is issued after the reset edge.
- Address math: word = (address - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits.
  - Low half-word is at sram_addr = {word, 1'b0}; high half-word is at {word, 1'b1}.
  - address[1:0] is ignored.
- Request: req = mem_read | mem_write. If both are asserted, the access is a write.
- States: IDLE, LO, HI, DONE. A 4-bit counter cnt is used within LO and HI.
- IDLE:
  - If req: latch address, write_data and op (write/read); go to LO with cnt=0.
  - Otherwise stay in IDLE.
- LO:
  - sram_addr = low address.
  - For a write: sram_dq_out = wd[15:0], oe=1, we_n=0.
  - For a read: oe=0, we_n=1.
  - cnt increments each clock.
  - When cnt==WAIT_CYCLES-1: a read captures sram_dq_in into read_data[15:0]; cnt returns to 0; go to HI.
- HI:
  - Same as LO, using the high address and wd[31:16]; a read captures into read_data[31:16].
  - When cnt==WAIT_CYCLES-1, go to DONE.
  - we_n returns to 1 and oe to 0 in the DONE cycle.
- DONE: ready=1 for exactly one cycle, then go to IDLE unconditionally. The pipeline advances on this edge.
- ready (combinational): 1 in DONE, or in IDLE when req=0. It is 0 in LO and HI, and in IDLE when req=1.
- Latency: request seen in IDLE at cycle 0; DONE occurs at cycle 2*WAIT_CYCLES+1.
  - ready is low for 2*WAIT_CYCLES+1 cycles (7 with the defaults).
- read_data holds its last loaded value until the next read completes; writes do not change it.
- Request inputs are ignored outside IDLE; changes to mem_read/mem_write/address mid-access have no effect.
- Back-to-back: a request still asserted in the IDLE cycle after DONE starts a new access (the next instruction's access).
- No request ever produces an SRAM strobe in IDLE or DONE.

Test Plan:
- Reset: drive rst=1 for 2 cycles during a write in LO -> next cycle we_n=1, oe=0, read_data=0, ready=1 with mem_read=mem_write=0.
- Write: mem_write=1, address=1028, write_data=0xDEADBEEF, WAIT_CYCLES=3 ->
  - sram_addr=2, dq_out=0xBEEF, we_n=0 for 3 cycles;
  - then sram_addr=3, dq_out=0xDEAD, we_n=0 for 3 cycles;
  - then ready=1 for 1 cycle.
- Read: SRAM model preloaded with [2]=0xBEEF, [3]=0xDEAD; mem_read=1, address=1028 -> ready low 7 cycles, then read_data=0xDEADBEEF with ready=1; oe=0 throughout.
- Idle: mem_read=mem_write=0 for 20 cycles -> ready=1, we_n=1, oe=0 constant, read_data unchanged.
- Both asserted: mem_read=mem_write=1, address=1024, write_data=0x00010002 -> write occurs at sram_addr 0/1 with data 0x0002/0x0001; read_data unchanged.
- Back-to-back: write 0x12345678 to 1032, then a read of 1032 held asserted -> second access starts the cycle after DONE; read returns 0x12345678 after a further 7 cycles.

Source files
------------

// File: rtl/sram_controller_if.sv
// MEM-stage request/response and external SRAM pad signals of the SRAM controller.
interface sram_controller_if #(
    parameter int SRAM_AW = 18
);
    logic               mem_read;
    logic               mem_write;
    logic [31:0]        address;
    logic [31:0]        write_data;
    logic [31:0]        read_data;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic               sram_dq_oe;
    logic [15:0]        sram_dq_in;
    logic               sram_we_n;

    modport master (
        output mem_read, mem_write, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  mem_read, mem_write, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into two 16-bit SRAM phases; latency 2*WAIT_CYCLES+1 clocks.
// Backpressure: ready is held low from the request cycle until DONE so the pipeline freezes.
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 3,
    parameter int SRAM_AW     = 18
) (
    input  logic             clk,
    input  logic             rst,
    sram_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         cnt;
    logic [3:0]         cnt_nxt;
    logic               op_wr;
    logic [SRAM_AW-2:0] word;
    logic [31:0]        wd;
    logic [31:0]        rd_q;
    logic               req;
    logic               phase_end;

    // A simultaneous read+write request is treated as a write.
    assign req       = bus.mem_read | bus.mem_write;
    assign phase_end = (cnt == LAST);
    assign bus.read_data = rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = LO;
                    cnt_nxt   = '0;
                end
            end
            LO, HI: begin
                if (phase_end) begin
                    cnt_nxt   = '0;
                    state_nxt = (state == LO) ? HI : DONE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr <= 1'b0;
            word  <= '0;
            wd    <= '0;
            rd_q  <= '0;
        end else begin
            if (state == IDLE && req) begin
                op_wr <= bus.mem_write;
                word  <= (SRAM_AW-1)'((bus.address - 32'(BASE_ADDR)) >> 2);
                wd    <= bus.write_data;
            end
            // Sample the pad on the last wait cycle of each read phase.
            if (!op_wr && phase_end) begin
                if (state == LO) rd_q[15:0]  <= bus.sram_dq_in;
                if (state == HI) rd_q[31:16] <= bus.sram_dq_in;
            end
        end
    end

    always_comb begin
        bus.sram_addr   = '0;
        bus.sram_dq_out = '0;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_we_n   = 1'b1;
        bus.ready       = (state == DONE) || (state == IDLE && !req);
        if (state == LO || state == HI) begin
            bus.sram_addr = {word, state == HI};
            if (op_wr) begin
                bus.sram_dq_out = (state == HI) ? wd[31:16] : wd[15:0];
                bus.sram_dq_oe  = 1'b1;
                bus.sram_we_n   = 1'b0;
            end
        end
    end
endmodule
